// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - request/result bundle for hilo_muldiv; HILO_MOVE_EN adds mthi/mtlo signals
interface hilo_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
`ifdef HILO_MOVE_EN
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
`endif
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

`ifdef HILO_MOVE_EN
    modport master (output start, op, a, b, flush, wr_hi, wr_lo, wdata,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
                    output busy, done, div_by_zero, hi, lo);
`else
    modport master (output start, op, a, b, flush,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, a, b, flush,
                    output busy, done, div_by_zero, hi, lo);
`endif
endinterface

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative 32x32 mult/div unit with HI/LO registers; HILO_MOVE_EN enables mthi/mtlo
module hilo_muldiv (
    input  logic         clk,
    input  logic         reset_n,
    hilo_muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic [31:0] a_q, a_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        bzero_q, bzero_d;
    logic        res_neg_q, res_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        accept;
    logic        is_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [63:0] prod;

    assign accept    = (state_q == IDLE) && bus.start && !bus.flush;
    assign is_signed = !bus.op[0];
    assign a_neg     = is_signed && bus.a[31];
    assign b_neg     = is_signed && bus.b[31];
    assign a_mag     = a_neg ? (~bus.a + 32'd1) : bus.a;
    assign b_mag     = b_neg ? (~bus.b + 32'd1) : bus.b;

    // Shift-add: acc_hi accumulates the partial product, acc_lo shifts out multiplier bits
    // and shifts in the low product bits.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Restoring division: acc_hi holds the remainder, acc_lo shifts dividend bits out and
    // quotient bits in.
    assign rem_sh  = {acc_hi_q, acc_lo_q[31]};
    assign prod    = res_neg_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

    // Control sequencing: 32 iterations then FIN; flush aborts from any busy state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.op[1] ? DIV : MUL;
                    cnt_d   = 6'd0;
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end
    end

    // Datapath: operand capture, one iteration per cycle, sign fix-up and HI/LO write in FIN.
    always_comb begin
        div_d     = div_q;
        a_d       = a_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bzero_d   = bzero_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        if (accept) begin
            div_d     = bus.op[1];
            a_d       = bus.a;
            opnd_d    = bus.op[1] ? b_mag : a_mag;
            acc_hi_d  = 32'd0;
            acc_lo_d  = bus.op[1] ? a_mag : b_mag;
            bzero_d   = (bus.b == 32'd0);
            res_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
        end else if (state_q == IDLE) begin
`ifdef HILO_MOVE_EN
            if (bus.wr_hi) hi_d = bus.wdata;
            if (bus.wr_lo) lo_d = bus.wdata;
`endif
        end else if (!bus.flush) begin
            case (state_q)
                MUL: begin
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                end
                DIV: begin
                    if (rem_sh >= {1'b0, opnd_q}) begin
                        acc_hi_d = rem_sh[31:0] - opnd_q;
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_sh[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end
                FIN: begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (bzero_q) begin
                        hi_d  = a_q;
                        lo_d  = 32'hFFFF_FFFF;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = res_neg_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
                        hi_d = rem_neg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            div_q     <= 1'b0;
            a_q       <= 32'd0;
            opnd_q    <= 32'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            bzero_q   <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            a_q       <= a_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            bzero_q   <= bzero_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized self-checking bench for hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hilo_muldiv_if bus ();

    hilo_muldiv dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'b01: begin p = ua * ub;      return {1'b0, p}; end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {1'b0, r[31:0], q[31:0]};
                end
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Issues one request (caller sits just after a rising edge) and checks the full timeline.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [64:0] m;
        int          bad;
        m         = model(op, a, b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            if (i == 16) check({tag, "_hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        end
        check({tag, "_busy"}, 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done"}, {bus.done, bus.busy}, 2'b10);
        check({tag, "_hilo"}, {bus.hi, bus.lo}, m[63:0]);
        check({tag, "_dbz"}, bus.div_by_zero, m[64]);
        exp_hi = m[63:32];
        exp_lo = m[31:0];
    endtask

    initial begin
        int          bad;
        int          sel;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.flush = 1'b0;
`ifdef HILO_MOVE_EN
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = 32'd0;
`endif
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_flags", {bus.busy, bus.done, bus.div_by_zero}, 3'b000);
        reset_n = 1'b1;

        // directed cases, issued back-to-back in each done cycle
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         "mult_m3x7");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_m7d2");
        run_op(2'b11, 32'd100,       32'd0,         "divu_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b10, 32'h8000_0007, 32'd0,         "div_by0");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min");
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, "div_7dm2");

        // flush mid-divide, with an ignored start while busy
        bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 begin bus.op = 2'b00; bus.start = 1'b1; end
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(posedge clk);
        #1;
        check("flush_busy", bus.busy, 1'b0);
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        check("flush_quiet", 64'(bad), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});

        // flush in IDLE blocks a same-cycle start
        bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        check("idle_flush_start", bus.busy, 1'b0);

        // asynchronous reset in the middle of a multiply
        bus.op = 2'b00; bus.a = 32'h0012_3456; bus.b = 32'hFFFF_0789; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midreset_flags", {bus.busy, bus.done, bus.div_by_zero}, 3'b000);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_op(2'b00, 32'h0012_3456, 32'hFFFF_0789, "after_reset");

`ifdef HILO_MOVE_EN
        bus.wdata = 32'h1234_5678; bus.wr_hi = 1'b1;
        @(posedge clk);
        #1 bus.wr_hi = 1'b0;
        check("mthi_idle", bus.hi, 32'h1234_5678);
        exp_hi = 32'h1234_5678;
        bus.wdata = 32'hCAFE_F00D; bus.wr_hi = 1'b1; bus.wr_lo = 1'b1;
        @(posedge clk);
        #1 begin bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; end
        check("mthilo_both", {bus.hi, bus.lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        exp_hi = 32'hCAFE_F00D;
        exp_lo = 32'hCAFE_F00D;
        bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
        bus.wdata = 32'h1234_5678; bus.wr_hi = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.wr_hi = 1'b0;
        check("mthi_busy", {bus.hi, bus.lo}, {exp_hi, exp_lo});
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("mthi_flush", {bus.busy, bus.hi}, {1'b0, exp_hi});
`endif

        // randomized operations
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel < 3) rb = $urandom_range(1, 15);
            else if (sel == 3) rb = 32'd0 - $urandom_range(1, 15);
            else if (sel == 4) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", n, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
